// File: rtl/digital_io_bridge_pkg.sv
// Shared definitions for the CPU-to-device I/O bridge: FSM encoding,
// byte-lane masks and the timeout error pattern.
package digital_io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [3:0]  BMASK_BYTE     = 4'b0001;
    localparam logic [3:0]  BMASK_HALF     = 4'b0011;
    localparam logic [3:0]  BMASK_WORD     = 4'b1111;
    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    function automatic logic [3:0] byte_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            2'd0:    mask = BMASK_BYTE;
            2'd1:    mask = BMASK_HALF;
            2'd2:    mask = BMASK_WORD;
            default: mask = BMASK_WORD;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/digital_io_timeout.sv
// Device-ready watchdog for the I/O bridge; compiled only when
// DIGITAL_IO_BRIDGE_TIMEOUT_EN is defined.
`ifdef DIGITAL_IO_BRIDGE_TIMEOUT_EN
module digital_io_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Count cycles spent waiting; saturate at the last one so expiry holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (!run) begin
            count_r <= '0;
        end else if (count_r != LAST) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = run && (count_r == LAST);

endmodule
`endif

// File: rtl/digital_io_bridge.sv
// CPU-to-multi-channel device bridge with read bursts and invalid-channel errors.
// Optional device-ready timeout enabled by DIGITAL_IO_BRIDGE_TIMEOUT_EN.
module digital_io_bridge
    import digital_io_bridge_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 32,
    parameter int CH_SEL_LSB     = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        io_addr,
    input  logic                     io_read,
    input  logic                     io_write,
    input  logic                     burst,
    input  logic [2:0]               burst_size,
    input  logic                     read_ready,
    input  logic [ADDR_W-1:0]        io_wdata,
    input  logic [1:0]               io_byte_size,
    output logic [ADDR_W-1:0]        io_rdata,
    output logic                     io_ready,
    output logic                     io_err,
    output logic [NUM_CH*ADDR_W-1:0] dev_addr,
    output logic [NUM_CH-1:0]        dev_read_en,
    output logic [NUM_CH-1:0]        dev_write_en,
    output logic [NUM_CH*4-1:0]      dev_byte_size,
    output logic [NUM_CH*ADDR_W-1:0] dev_wdata,
    input  logic [NUM_CH*ADDR_W-1:0] dev_rdata,
    input  logic [NUM_CH-1:0]        dev_ready
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e              state_r, next_state_s;
    logic [ADDR_W-1:0]   addr_r, addr_nx, wdata_r, wdata_nx, rdata_nx, sel_rdata_s;
    logic [CH_W-1:0]     ch_r, ch_nx, ch_sel_s;
    logic [3:0]          bmask_r, bmask_nx, beats_r, beats_nx;
    logic                write_r, write_nx, bad_r, bad_nx, bad_s;
    logic                ready_nx, err_nx, sel_ready_s, timeout_s, run_s;

    assign ch_sel_s = (NUM_CH > 1) ? io_addr[CH_SEL_LSB +: CH_W] : '0;
    assign bad_s    = (32'(ch_sel_s) >= 32'(NUM_CH));
    assign run_s    = (state_r == ST_WAIT);

`ifdef DIGITAL_IO_BRIDGE_TIMEOUT_EN
    digital_io_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Select ready/data of the latched channel only; others are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rdata_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_ready_s = sel_ready_s | ((ch_r == CH_W'(i)) & dev_ready[i]);
            sel_rdata_s = sel_rdata_s | ({ADDR_W{ch_r == CH_W'(i)}} & dev_rdata[i*ADDR_W +: ADDR_W]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state plus next values of the latched request and CPU-side outputs.
    always_comb begin
        next_state_s = state_r;
        addr_nx  = addr_r;
        ch_nx    = ch_r;
        wdata_nx = wdata_r;
        bmask_nx = bmask_r;
        write_nx = write_r;
        bad_nx   = bad_r;
        beats_nx = beats_r;
        rdata_nx = io_rdata;
        ready_nx = 1'b0;
        err_nx   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (io_write || io_read) begin
                    addr_nx  = io_addr;
                    ch_nx    = ch_sel_s;
                    wdata_nx = io_wdata;
                    bmask_nx = byte_mask(io_byte_size);
                    write_nx = io_write;
                    bad_nx   = bad_s;
                    beats_nx = (!io_write && burst) ? ({1'b0, burst_size} + 4'd1) : 4'd1;
                    if (bad_s) begin
                        next_state_s = ST_RESP;
                        ready_nx     = 1'b1;
                        err_nx       = 1'b1;
                        rdata_nx     = '0;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_ready_s) begin
                    next_state_s = ST_RESP;
                    ready_nx     = 1'b1;
                    rdata_nx     = write_r ? io_rdata : sel_rdata_s;
                end else if (timeout_s) begin
                    // Forcing the beat count to one aborts the rest of a burst.
                    next_state_s = ST_RESP;
                    ready_nx     = 1'b1;
                    err_nx       = 1'b1;
                    rdata_nx     = ADDR_W'(TIMEOUT_PATTERN);
                    beats_nx     = 4'd1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (write_r) begin
                    next_state_s = ST_IDLE;
                end else if (read_ready) begin
                    if (beats_r > 4'd1) begin
                        beats_nx = beats_r - 4'd1;
                        addr_nx  = addr_r + ADDR_W'(4);
                        if (bad_r) begin
                            next_state_s = ST_RESP;
                            ready_nx     = 1'b1;
                            err_nx       = 1'b1;
                            rdata_nx     = '0;
                        end else begin
                            next_state_s = ST_REQ;
                        end
                    end else begin
                        next_state_s = ST_IDLE;
                        beats_nx     = 4'd0;
                    end
                end else begin
                    next_state_s = ST_RESP;
                    ready_nx     = 1'b1;
                    err_nx       = io_err;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Latched request, registered CPU outputs and one-cycle device strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r        <= '0;
            ch_r          <= '0;
            wdata_r       <= '0;
            bmask_r       <= 4'd0;
            write_r       <= 1'b0;
            bad_r         <= 1'b0;
            beats_r       <= 4'd0;
            io_rdata      <= '0;
            io_ready      <= 1'b0;
            io_err        <= 1'b0;
            dev_addr      <= '0;
            dev_read_en   <= '0;
            dev_write_en  <= '0;
            dev_byte_size <= '0;
            dev_wdata     <= '0;
        end else begin
            addr_r        <= addr_nx;
            ch_r          <= ch_nx;
            wdata_r       <= wdata_nx;
            bmask_r       <= bmask_nx;
            write_r       <= write_nx;
            bad_r         <= bad_nx;
            beats_r       <= beats_nx;
            io_rdata      <= rdata_nx;
            io_ready      <= ready_nx;
            io_err        <= err_nx;
            dev_addr      <= '0;
            dev_read_en   <= '0;
            dev_write_en  <= '0;
            dev_byte_size <= '0;
            dev_wdata     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if ((next_state_s == ST_REQ) && (ch_nx == CH_W'(i))) begin
                    dev_read_en[i]                 <= !write_nx;
                    dev_write_en[i]                <= write_nx;
                    dev_addr[i*ADDR_W +: ADDR_W]   <= addr_nx;
                    dev_wdata[i*ADDR_W +: ADDR_W]  <= wdata_nx;
                    dev_byte_size[i*4 +: 4]        <= bmask_nx;
                end else begin
                    dev_read_en[i]  <= 1'b0;
                    dev_write_en[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_digital_io_bridge.sv
// Randomized self-checking bench for digital_io_bridge (3 channels so that
// channel index 3 is invalid); timeout checks follow DIGITAL_IO_BRIDGE_TIMEOUT_EN.
module tb_digital_io_bridge;
    localparam int NUM_CH = 3;
    localparam int AW     = 32;
    localparam int TO     = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [AW-1:0]      io_addr = '0, io_wdata = '0, io_rdata;
    logic               io_read = 1'b0, io_write = 1'b0, burst = 1'b0, read_ready = 1'b0;
    logic [2:0]         burst_size = 3'd0;
    logic [1:0]         io_byte_size = 2'd0;
    logic               io_ready, io_err;
    logic [NUM_CH*AW-1:0] dev_addr, dev_wdata;
    logic [NUM_CH*AW-1:0] dev_rdata = '0;
    logic [NUM_CH-1:0]  dev_read_en, dev_write_en;
    logic [NUM_CH-1:0]  dev_ready = '0;
    logic [NUM_CH*4-1:0] dev_byte_size;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digital_io_bridge #(.NUM_CH(NUM_CH), .ADDR_W(AW), .CH_SEL_LSB(28), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
        .burst(burst), .burst_size(burst_size), .read_ready(read_ready), .io_wdata(io_wdata),
        .io_byte_size(io_byte_size), .io_rdata(io_rdata), .io_ready(io_ready), .io_err(io_err),
        .dev_addr(dev_addr), .dev_read_en(dev_read_en), .dev_write_en(dev_write_en),
        .dev_byte_size(dev_byte_size), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_ready(dev_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte lanes enabled: 1, 2 or 4 bytes (sizes 2 and 3 both mean a word).
    function automatic logic [3:0] ref_mask(input logic [1:0] bs);
        int bytes;
        bytes = (bs >= 2'd2) ? 4 : (1 << bs);
        return 4'((1 << bytes) - 1);
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input int c);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, io_rdata, 64'd0);
        check({tag, "_ready_err"}, {io_ready, io_err}, 64'd0);
        check({tag, "_dev_en"}, {dev_read_en, dev_write_en}, 64'd0);
        check({tag, "_dev_addr"}, (dev_addr == '0), 64'd1);
        check({tag, "_dev_wdata"}, (dev_wdata == '0), 64'd1);
        check({tag, "_dev_bsize"}, dev_byte_size, 64'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; io_read = 1'b0; io_write = 1'b0; read_ready = 1'b0; dev_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Read (optionally burst); fixed_d > 0 forces the device delay after each strobe.
    task automatic do_read(input logic [31:0] addr, input logic b, input logic [2:0] bs,
                           input logic [1:0] by, input int fixed_d);
        int ch, nb, d, hold;
        logic [31:0] a, data;
        logic bad;
        ch  = int'(addr[29:28]);
        bad = (ch >= NUM_CH);
        nb  = b ? int'(bs) + 1 : 1;
        data = '0;
        @(negedge clk);
        io_addr = addr; io_read = 1'b1; burst = b; burst_size = bs;
        io_byte_size = by; io_wdata = $urandom;
        for (int k = 0; k < nb; k++) begin
            a = addr + 32'(4 * k);
            @(negedge clk);
            read_ready = 1'b0;
            if (bad) begin
                check("bad_rd_no_strobe", {dev_read_en, dev_write_en}, 64'd0);
                check("bad_rd_ready", io_ready, 64'd1);
                check("bad_rd_err", io_err, 64'd1);
                check("bad_rd_rdata", io_rdata, 64'd0);
                data = '0;
                io_read = 1'b0;
            end else begin
                check("rd_strobe", dev_read_en, 64'(onehot(ch)));
                check("rd_no_wr", dev_write_en, 64'd0);
                check("rd_addr", dev_addr[ch*AW +: AW], 64'(a));
                check("rd_bsize", dev_byte_size[ch*4 +: 4], 64'(ref_mask(by)));
                d = (fixed_d > 0) ? fixed_d : $urandom_range(1, 4);
                data = $urandom;
                for (int j = 1; j <= d; j++) begin
                    @(negedge clk);
                    dev_ready = '0;
                    check("rd_not_early", io_ready, 64'd0);
                    check("rd_single_strobe", dev_read_en, 64'd0);
                    dev_rdata = {$urandom, $urandom, $urandom};
                    if (j == d) begin
                        dev_ready[ch] = 1'b1;
                        dev_rdata[ch*AW +: AW] = data;
                    end else begin
                        dev_ready[(ch + 1) % NUM_CH] = 1'b1;
                    end
                end
                @(negedge clk);
                dev_ready = '0;
                check("rd_ready", io_ready, 64'd1);
                check("rd_data", io_rdata, 64'(data));
                check("rd_err", io_err, 64'd0);
                io_read = 1'b0;
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rd_hold_ready", io_ready, 64'd1);
                check("rd_hold_data", io_rdata, 64'(data));
            end
            read_ready = 1'b1;
        end
        @(negedge clk);
        read_ready = 1'b0;
        check("rd_done_idle", io_ready, 64'd0);
        check("rd_done_quiet", {dev_read_en, dev_write_en}, 64'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] by, input logic both);
        int ch, d;
        ch = int'(addr[29:28]);
        @(negedge clk);
        io_addr = addr; io_wdata = data; io_byte_size = by; io_write = 1'b1; io_read = both;
        burst = 1'b1; burst_size = 3'd7;
        @(negedge clk);
        if (ch >= NUM_CH) begin
            check("bad_wr_no_strobe", {dev_read_en, dev_write_en}, 64'd0);
            check("bad_wr_ready", io_ready, 64'd1);
            check("bad_wr_err", io_err, 64'd1);
            check("bad_wr_rdata", io_rdata, 64'd0);
        end else begin
            check("wr_strobe", dev_write_en, 64'(onehot(ch)));
            check("wr_no_rd", dev_read_en, 64'd0);
            check("wr_addr", dev_addr[ch*AW +: AW], 64'(addr));
            check("wr_wdata", dev_wdata[ch*AW +: AW], 64'(data));
            check("wr_bsize", dev_byte_size[ch*4 +: 4], 64'(ref_mask(by)));
            d = $urandom_range(1, 3);
            for (int j = 1; j <= d; j++) begin
                @(negedge clk);
                dev_ready = '0;
                check("wr_not_early", io_ready, 64'd0);
                if (j == d) dev_ready[ch] = 1'b1;
                else        dev_ready[(ch + 2) % NUM_CH] = 1'b1;
            end
            @(negedge clk);
            dev_ready = '0;
            check("wr_ready", io_ready, 64'd1);
            check("wr_err", io_err, 64'd0);
        end
        io_write = 1'b0; io_read = 1'b0;
        @(negedge clk);
        check("wr_ready_one_cycle", io_ready, 64'd0);
        check("wr_done_quiet", {dev_read_en, dev_write_en}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, kind, ch;
        logic [31:0] a;
        logic seen;

        #1;
        check_all_zero("reset");
        reset_dut();
        check_all_zero("after_release");

        do_read(32'h1000_0010, 1'b0, 3'd0, 2'd2, 1);   // single read, 3-cycle latency on channel 1
        do_read(32'h0000_0100, 1'b1, 3'd3, 2'd2, 0);   // four-beat burst on channel 0
        do_write(32'h0000_0020, 32'h0000_A5A5, 2'd1, 1'b0);
        do_write(32'h2000_0044, 32'h1234_5678, 2'd0, 1'b1); // write wins over read
        do_read(32'hF000_0000, 1'b0, 3'd0, 2'd2, 0);   // invalid channel
        do_read(32'h3000_0000, 1'b1, 3'd2, 2'd0, 0);   // invalid channel burst
        do_write(32'hF000_0008, 32'hCAFE_F00D, 2'd2, 1'b0);
        do_read(32'h2FFF_FFF8, 1'b1, 3'd2, 2'd1, 0);   // address crosses select field, channel stays 2

        for (int r = 0; r < 16; r++) begin
            kind = $urandom_range(0, 2);
            ch   = $urandom_range(0, 3);
            a = $urandom;
            a[29:28] = 2'(ch);
            a[1:0] = 2'b00;
            if (kind == 0) do_write(a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else           do_read(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 0);
        end

        // Reset during the wait of beat 2 of a burst.
        @(negedge clk);
        io_addr = 32'h0000_0200; io_read = 1'b1; burst = 1'b1; burst_size = 3'd3;
        @(negedge clk);
        check("rst_b1_strobe", dev_read_en, 64'(onehot(0)));
        @(negedge clk);
        dev_ready[0] = 1'b1; dev_rdata[0 +: AW] = 32'h1111_2222;
        @(negedge clk);
        dev_ready = '0;
        check("rst_b1_data", io_rdata, 64'h1111_2222);
        io_read = 1'b0; read_ready = 1'b1;
        @(negedge clk);
        read_ready = 1'b0;
        check("rst_b2_strobe", dev_read_en, 64'(onehot(0)));
        check("rst_b2_addr", dev_addr[0 +: AW], 64'h204);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_burst_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dev_ready[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dev_ready = '0;
            seen = seen | io_ready | (|dev_read_en) | (|dev_write_en);
        end
        check("late_ready_ignored", seen, 64'd0);

        // Device that never answers.
        @(negedge clk);
        io_addr = 32'h1000_0040; io_read = 1'b1; burst = 1'b1; burst_size = 3'd2;
        @(negedge clk);
        check("to_strobe", dev_read_en, 64'(onehot(1)));
        cnt = 0;
        while (cnt < 40 && io_ready !== 1'b1) begin
            @(negedge clk);
            cnt++;
        end
`ifdef DIGITAL_IO_BRIDGE_TIMEOUT_EN
        check("to_latency", cnt, 64'd17);
        check("to_rdata", io_rdata, 64'hDEAD_BEEF);
        check("to_err", io_err, 64'd1);
        io_read = 1'b0; read_ready = 1'b1;
        @(negedge clk);
        read_ready = 1'b0;
        check("to_abort_ready", io_ready, 64'd0);
        check("to_abort_strobe", dev_read_en, 64'd0);
        @(negedge clk);
        check("to_abort_idle", {io_ready, dev_read_en}, 64'd0);
`else
        check("no_timeout_waits", cnt, 64'd40);
        check("no_timeout_err", io_err, 64'd0);
        io_read = 1'b0;
        reset_dut();
        check_all_zero("after_wait_reset");
`endif

        do_read(32'h0000_0300, 1'b0, 3'd0, 2'd2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/digital_io_bridge.md
DIGITAL_IO_BRIDGE -- requirements
Module: digital_io_bridge

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 2, number of device channels (1..8); ADDR_W, default 32, address/data width; CH_SEL_LSB, default 28, lowest address bit of the channel select field; TIMEOUT_CYCLES, default 255, device-ready timeout.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 CPU-side inputs: io_addr[ADDR_W]; io_read[1]; io_write[1]; burst[1]; burst_size[3]; read_ready[1]; io_wdata[ADDR_W]; io_byte_size[2].
REQ-006 CPU-side outputs: io_rdata[ADDR_W]; io_ready[1]; io_err[1].
REQ-007 Channel outputs, each flattened NUM_CH-wide with channel i at slice i: dev_addr[NUM_CH*ADDR_W]; dev_read_en[NUM_CH]; dev_write_en[NUM_CH]; dev_byte_size[NUM_CH*4]; dev_wdata[NUM_CH*ADDR_W].
REQ-008 Channel inputs, same flattening: dev_rdata[NUM_CH*ADDR_W]; dev_ready[NUM_CH].

Function
REQ-009 Channel index SHALL be io_addr[CH_SEL_LSB +: clog2(NUM_CH)], latched at acceptance; it SHALL NOT change during a burst.
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-011 IDLE: on io_read or io_write, latch addr, channel, wdata, byte size and direction, then go to REQ; io_write wins if both are asserted.
REQ-012 Beat count SHALL be burst_size+1 (1..8) for reads with burst=1, and 1 otherwise; writes ignore burst.
REQ-013 REQ: for exactly one cycle, drive the selected channel's read_en or write_en, addr, wdata and byte_size; go to WAIT.
REQ-014 Byte-size mapping SHALL be 0 -> 4'b0001, 1 -> 4'b0011, 2 -> 4'b1111, 3 -> 4'b1111.
REQ-015 WAIT: on dev_ready of the latched channel, capture dev_rdata (reads only) into io_rdata and go to RESP; dev_ready on other channels SHALL be ignored.
REQ-016 RESP, write: io_ready is high for one cycle, then the FSM goes to IDLE.
REQ-017 RESP, read: io_ready and io_rdata are held until read_ready; then, if beats remain, addr += 4 (modulo 2^ADDR_W) and the FSM goes to REQ; otherwise it goes to IDLE.
REQ-018 A request level still present in IDLE SHALL be treated as a new request; the CPU deasserts io_read/io_write on io_ready.
REQ-019 Channel index >= NUM_CH: go directly to RESP with io_rdata=0 and io_err=1 for every beat; no device strobe.
REQ-020 Latency SHALL be 3 cycles from request acceptance to the first io_ready when the device is ready in the cycle after the strobe.
REQ-021 Only the selected channel's enables SHALL ever be high; all others stay 0.

Reset
REQ-022 Asserting rst_n low at any time, including mid-burst, SHALL force state IDLE and clear the beat counter.
REQ-023 On reset, every output SHALL be 0, including io_rdata and all dev_* outputs.
REQ-024 After reset release, a late dev_ready from an aborted access SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-025 With DIGITAL_IO_BRIDGE_TIMEOUT_EN defined, a WAIT lasting TIMEOUT_CYCLES cycles SHALL go to RESP with io_rdata=32'hDEADBEEF and io_err=1 and SHALL abort any remaining beats.
REQ-026 Without DIGITAL_IO_BRIDGE_TIMEOUT_EN, WAIT SHALL wait indefinitely and io_err SHALL assert only per REQ-019.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the byte-size mapping constants and the timeout error pattern 32'hDEADBEEF.
REQ-028 The timeout counter SHALL be a sub-module named digital_io_timeout, instantiated only under the macro.

Verification
REQ-029 Single read: NUM_CH=2, io_addr=0x1000_0010, dev_ready one cycle after the strobe -> channel 1 read_en pulses with addr 0x1000_0010, and io_ready asserts 3 cycles after acceptance with dev_rdata.
REQ-030 Read burst: burst=1, burst_size=3, addr 0x0000_0100 -> four strobes on channel 0 at 0x100/0x104/0x108/0x10C; each beat holds until read_ready.
REQ-031 Write: io_byte_size=1, wdata 0xA5A5 -> dev_byte_size=4'b0011, one write_en pulse and a one-cycle io_ready.
REQ-032 Invalid channel: NUM_CH=3, addr 0xF000_0000 -> io_ready with io_rdata=0 and io_err=1; no dev strobes.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=16): dev_ready never asserts -> io_rdata=0xDEADBEEF and io_err=1 after 16 WAIT cycles; a burst aborts.
REQ-034 Reset during WAIT of beat 2 of a burst -> all outputs 0 and IDLE; a subsequent dev_ready produces no io_ready.
